// File: rtl/cdb_arbiter_pkg.sv
// Shared types and widths for the execute-stage result / CDB interface.
package cdb_arbiter_pkg;

  localparam int NUM_CDB_SRC = 4;
  localparam int XLEN        = 32;
  localparam int PHYS_TAG_W  = 6;
  localparam int ROB_IDX_W   = 5;

  // One finished functional-unit result as carried on the CDB.
  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic [PHYS_TAG_W-1:0] dest_tag;
    logic [ROB_IDX_W-1:0]  rob_idx;
    logic                  take_branch;
    logic [XLEN-1:0]       branch_target;
  } FU_RESULT_PACKET;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after start, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid
);

  // Scan start, start+1, ... modulo N and take the first set request.
  always_comb begin
    int cand;
    cand       = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_valid  = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(start) + k) % N;
      if (!gnt_valid && req[cand]) begin
        gnt_valid        = 1'b1;
        gnt_idx          = $clog2(N)'(cand);
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one-entry holding buffer per functional unit, one round-robin
// broadcast per cycle. The grant is locked while a broadcast is stalled so the
// payload cannot change under a stalled consumer.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_CDB_SRC
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  FU_RESULT_PACKET [NUM_SRC-1:0] src_packet,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic                         cdb_ready,
  output logic                         cdb_valid,
  output FU_RESULT_PACKET              cdb_packet,
  output logic [$clog2(NUM_SRC)-1:0]   cdb_src
);

  localparam int IW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] full;
  FU_RESULT_PACKET    payload [NUM_SRC];
  logic [IW-1:0]      rr_ptr;
  logic               locked;
  logic [IW-1:0]      lock_idx;

  logic [NUM_SRC-1:0] arb_onehot;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;
  logic [IW-1:0]      grant;
  logic [IW-1:0]      grant_next;
  logic               fire;
  logic [NUM_SRC-1:0] accept;

  rr_arbiter #(.N(NUM_SRC)) u_rr (
    .req        (full),
    .start      (rr_ptr),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .gnt_valid  (arb_valid)
  );

  // Grant selection, broadcast outputs and per-source ready.
  always_comb begin
    grant      = locked ? lock_idx : arb_idx;
    grant_next = (grant == IW'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
    cdb_valid  = arb_valid & ~flush & ~reset;
    fire       = cdb_valid & cdb_ready;
    cdb_packet = cdb_valid ? payload[grant] : '0;
    cdb_src    = cdb_valid ? grant : '0;
    src_ready  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = ~reset & ~flush & (~full[i] | (fire & (grant == IW'(i))));
    end
    accept = src_valid & src_ready;
  end

  // Buffer fill/drain, round-robin pointer and stall lock.
  always_ff @(posedge clock) begin
    if (reset) begin
      full     <= '0;
      rr_ptr   <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
      for (int i = 0; i < NUM_SRC; i++) payload[i] <= '0;
    end else if (flush) begin
      full   <= '0;
      locked <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept[i]) begin
          full[i]    <= 1'b1;
          payload[i] <= src_packet[i];
        end else if (fire && (grant == IW'(i))) begin
          full[i] <= 1'b0;
        end
      end
      if (fire) begin
        rr_ptr <= grant_next;
        locked <= 1'b0;
      end else if (cdb_valid) begin
        locked   <= 1'b1;
        lock_idx <= grant;
      end
    end
  end

endmodule
